// File: rtl/entities_mover_pkg.sv
// Shared definitions for the entities mover: field-type codes, move
// direction codes, object-map word layout and the mover FSM states.
package entities_mover_pkg;

  // Object-map field types
  localparam logic [2:0] FT_EMPTY       = 3'd0;
  localparam logic [2:0] FT_GOAL        = 3'd1;
  localparam logic [2:0] FT_WALL        = 3'd2;
  localparam logic [2:0] FT_COWBOY      = 3'd3;
  localparam logic [2:0] FT_COWBOY_GOAL = 3'd4;
  localparam logic [2:0] FT_BOX         = 3'd5;
  localparam logic [2:0] FT_BOX_GOAL    = 3'd6;

  // Move direction codes
  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  // Object-map word layout: [10:8] type, [7:2] animation offset, [1:0] dir
  localparam int WORD_W  = 11;
  localparam int TYPE_HI = 10;
  localparam int TYPE_LO = 8;
  localparam int OFS_HI  = 7;
  localparam int OFS_LO  = 2;
  localparam int DIR_HI  = 1;
  localparam int DIR_LO  = 0;

  typedef enum logic [2:0] {
    IDLE,
    WR_C,
    WR_N,
    WR_B,
    READY,
    WAIT_LOW
  } state_t;

  // Pack one object-map word
  function automatic logic [WORD_W-1:0] om_word(input logic [2:0] ftype,
                                                input logic [5:0] ofs,
                                                input logic [1:0] dir);
    return {ftype, ofs, dir};
  endfunction

endpackage

// File: rtl/entities_mover_if.sv
// Bundle of the mover's object-map write port, move handshake and the
// cell descriptions supplied by the game logic.
interface entities_mover_if;
  logic [6:0]  address_write_om;
  logic [10:0] data_write_om;
  logic        wren;
  logic [6:0]  cowboy_row_out;
  logic [6:0]  cowboy_col_out;
  logic        new_state_ready;
  logic        move_done;
  logic [6:0]  cowboy_row;
  logic [6:0]  cowboy_col;
  logic [10:0] pos_cowboy;
  logic [6:0]  other_row;
  logic [6:0]  other_col;
  logic [10:0] pos_other;
  logic        only_moving_cowboy;
  logic        process_move;
  logic [2:0]  field_type_after;

  // The mover side
  modport master (
    output address_write_om, data_write_om, wren,
    output cowboy_row_out, cowboy_col_out, new_state_ready, move_done,
    input  cowboy_row, cowboy_col, pos_cowboy, other_row, other_col,
    input  pos_other, only_moving_cowboy, process_move, field_type_after
  );

  // The game-logic / object-map side
  modport slave (
    input  address_write_om, data_write_om, wren,
    input  cowboy_row_out, cowboy_col_out, new_state_ready, move_done,
    output cowboy_row, cowboy_col, pos_cowboy, other_row, other_col,
    output pos_other, only_moving_cowboy, process_move, field_type_after
  );
endinterface

// File: rtl/first_lit.sv
// Isolates the lowest set bit of a 4-bit vector (zero when none set).
module first_lit (
  input  logic [3:0] bits,
  output logic [3:0] lowest
);
  // Two's-complement trick keeps only the least significant one
  assign lowest = bits & (~bits + 4'd1);
endmodule

// File: rtl/hextoseg.sv
// Hex digit to 7-segment pattern, active-low, bit order {g,f,e,d,c,b,a}.
module hextoseg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // Segment lookup for 0-F
  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/entities_mover.sv
// Entities mover: each process_move request produces one animation frame
// (cowboy cell, and pushed box cell, tagged with the frame number) or, on
// the last frame, commits the move by rewriting cowboy, neighbour and the
// cell beyond the neighbour in the object map.
module entities_mover
  import entities_mover_pkg::*;
#(
  parameter int ROW   = 10,
  parameter int STEPS = 8
) (
  input  logic clk,
  input  logic rst_n,
  entities_mover_if.master bus
);

  state_t      state_reg, state_next;
  logic [5:0]  k_reg;
  logic [6:0]  c_row_reg, c_col_reg, n_row_reg, n_col_reg;
  logic [2:0]  c_type_reg, n_type_reg, after_type_reg;
  dir_t        dir_reg;
  logic        only_cowboy_reg;
  logic [6:0]  cowboy_row_reg, cowboy_col_reg;

  logic        commit;
  logic        wren;
  logic [6:0]  addr;
  logic [10:0] data;
  logic        ready_pulse;
  logic        done_pulse;

  // Linear board address; truncation to 7 bits is intended
  function automatic logic [6:0] cell_addr(input logic [6:0] r, input logic [6:0] c);
    int full;
    full = int'(r) * ROW + int'(c);
    return full[6:0];
  endfunction

  // Address of the cell one step beyond (r,c) in direction d
  function automatic logic [6:0] step_addr(input logic [6:0] r, input logic [6:0] c,
                                           input dir_t d);
    logic [6:0] nr, nc;
    nr = r;
    nc = c;
    case (d)
      DIR_LEFT:  nc = c - 7'd1;
      DIR_RIGHT: nc = c + 7'd1;
      DIR_UP:    nr = r - 7'd1;
      default:   nr = r + 7'd1;
    endcase
    return cell_addr(nr, nc);
  endfunction

  // What the cowboy leaves behind: a goal stays a goal, anything else empties
  function automatic logic [2:0] vacated_type(input logic [2:0] t);
    return (t == FT_COWBOY_GOAL) ? FT_GOAL : FT_EMPTY;
  endfunction

  // Cowboy arriving on a cell keeps the goal marking of that cell
  function automatic logic [2:0] arrived_type(input logic [2:0] t);
    return (t == FT_GOAL || t == FT_BOX_GOAL) ? FT_COWBOY_GOAL : FT_COWBOY;
  endfunction

  assign commit = (k_reg == 6'(STEPS));

  // State, frame counter, latched move description and committed position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      k_reg           <= '0;
      c_row_reg       <= '0;
      c_col_reg       <= '0;
      n_row_reg       <= '0;
      n_col_reg       <= '0;
      c_type_reg      <= '0;
      n_type_reg      <= '0;
      after_type_reg  <= '0;
      dir_reg         <= DIR_LEFT;
      only_cowboy_reg <= 1'b0;
      cowboy_row_reg  <= '0;
      cowboy_col_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && bus.process_move) begin
        k_reg           <= k_reg + 6'd1;
        c_row_reg       <= bus.cowboy_row;
        c_col_reg       <= bus.cowboy_col;
        n_row_reg       <= bus.other_row;
        n_col_reg       <= bus.other_col;
        c_type_reg      <= bus.pos_cowboy[TYPE_HI:TYPE_LO];
        n_type_reg      <= bus.pos_other[TYPE_HI:TYPE_LO];
        after_type_reg  <= bus.field_type_after;
        dir_reg         <= dir_t'(bus.pos_cowboy[DIR_HI:DIR_LO]);
        only_cowboy_reg <= bus.only_moving_cowboy;
      end
      if (state_reg == READY && commit) begin
        k_reg          <= '0;
        cowboy_row_reg <= n_row_reg;
        cowboy_col_reg <= n_col_reg;
      end
    end
  end

  // Next state and Moore outputs for the current write/handshake phase
  always_comb begin
    state_next  = state_reg;
    wren        = 1'b0;
    addr        = '0;
    data        = '0;
    ready_pulse = 1'b0;
    done_pulse  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.process_move) state_next = WR_C;
      end
      WR_C: begin
        wren = 1'b1;
        addr = cell_addr(c_row_reg, c_col_reg);
        data = commit ? om_word(vacated_type(c_type_reg), 6'd0, 2'b00)
                      : om_word(c_type_reg, k_reg, dir_reg);
        if (!bus.process_move)                  state_next = IDLE;
        else if (only_cowboy_reg && !commit)    state_next = READY;
        else                                    state_next = WR_N;
      end
      WR_N: begin
        wren = 1'b1;
        addr = cell_addr(n_row_reg, n_col_reg);
        data = commit ? om_word(arrived_type(n_type_reg), 6'd0, 2'b00)
                      : om_word(n_type_reg, k_reg, dir_reg);
        if (!bus.process_move)                  state_next = IDLE;
        else if (commit && !only_cowboy_reg)    state_next = WR_B;
        else                                    state_next = READY;
      end
      WR_B: begin
        wren = 1'b1;
        addr = step_addr(n_row_reg, n_col_reg, dir_reg);
        data = om_word((after_type_reg == FT_GOAL) ? FT_BOX_GOAL : FT_BOX, 6'd0, 2'b00);
        if (!bus.process_move) state_next = IDLE;
        else                   state_next = READY;
      end
      READY: begin
        ready_pulse = 1'b1;
        done_pulse  = commit;
        state_next  = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.process_move) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.wren             = wren;
  assign bus.address_write_om = addr;
  assign bus.data_write_om    = data;
  assign bus.new_state_ready  = ready_pulse;
  assign bus.move_done        = done_pulse;
  assign bus.cowboy_row_out   = cowboy_row_reg;
  assign bus.cowboy_col_out   = cowboy_col_reg;

endmodule

// File: tb/tb_entities_mover.sv
// Directed bench for entities_mover with a write scoreboard, plus spot
// checks of the first_lit and hextoseg companion modules.
module tb_entities_mover;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [17:0] exp_q[$];

  logic [3:0] fl_bits, fl_lowest;
  logic [3:0] hx;
  logic [6:0] seg;

  always #5 clk = ~clk;

  entities_mover_if bus();

  entities_mover #(.ROW(10), .STEPS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  first_lit u_fl (.bits(fl_bits), .lowest(fl_lowest));
  hextoseg  u_hx (.hex(hx), .seg(seg));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [6:0] a, input logic [2:0] t, input logic [5:0] k,
                      input logic [1:0] d);
    exp_q.push_back({a, t, k, d});
  endtask

  task automatic set_move(input logic [6:0] cr, input logic [6:0] cc, input logic [2:0] ct,
                          input logic [1:0] d, input logic [6:0] nr, input logic [6:0] nc,
                          input logic [2:0] nt, input logic only, input logic [2:0] fta);
    bus.cowboy_row         = cr;
    bus.cowboy_col         = cc;
    bus.pos_cowboy         = {ct, 6'h3F, d};   // offset bits must be ignored
    bus.other_row          = nr;
    bus.other_col          = nc;
    bus.pos_other          = {nt, 8'hFF};      // low bits must be ignored
    bus.only_moving_cowboy = only;
    bus.field_type_after   = fta;
  endtask

  // Pop the oldest expected write and compare with what is on the bus
  task automatic check_write(input string tag);
    logic [17:0] e;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL %s_unexpected_write observed addr=%0d data=0x%0h expected none",
             tag, bus.address_write_om, bus.data_write_om);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_addr"}, 32'(bus.address_write_om), 32'(e[17:11]));
      chk({tag, "_data"}, 32'(bus.data_write_om), 32'(e[10:0]));
      $display("write %s addr=%0d data=0x%03h", tag, bus.address_write_om, bus.data_write_om);
    end
  endtask

  // One frame request; checks all writes, the pulse and move_done
  task automatic run_frame(input string tag, input logic exp_done, input int hold);
    bit seen = 0;
    bus.process_move = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.wren) check_write(tag);
      if (bus.new_state_ready) begin
        seen = 1;
        chk({tag, "_move_done"}, 32'(bus.move_done), 32'(exp_done));
      end
    end
    chk({tag, "_pulse_seen"}, 32'(seen), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_wren"}, 32'(bus.wren), 32'd0);
      chk({tag, "_hold_pulse"}, 32'(bus.new_state_ready), 32'd0);
    end
    bus.process_move = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_missing_writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bus.process_move = 1'b0;
    set_move(7'd0, 7'd0, 3'd0, 2'd0, 7'd0, 7'd0, 3'd0, 1'b0, 3'd0);
    fl_bits = 4'd0;
    hx = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wren", 32'(bus.wren), 32'd0);
    chk("rst_pulse", 32'(bus.new_state_ready), 32'd0);
    chk("rst_done", 32'(bus.move_done), 32'd0);
    chk("rst_addr", 32'(bus.address_write_om), 32'd0);
    chk("rst_data", 32'(bus.data_write_om), 32'd0);
    chk("rst_row_out", 32'(bus.cowboy_row_out), 32'd0);
    chk("rst_col_out", 32'(bus.cowboy_col_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cowboy-only move right from (4,3) to (4,4); frame 1 held high afterwards
    set_move(7'd4, 7'd3, 3'd3, 2'b01, 7'd4, 7'd4, 3'd0, 1'b1, 3'd0);
    push(7'd43, 3'd3, 6'd1, 2'b01);
    run_frame("walk_f1", 1'b0, 5);
    for (int k = 2; k < 8; k++) begin
      push(7'd43, 3'd3, 6'(k), 2'b01);
      run_frame($sformatf("walk_f%0d", k), 1'b0, 0);
    end
    push(7'd43, 3'd0, 6'd0, 2'b00);
    push(7'd44, 3'd3, 6'd0, 2'b00);
    run_frame("walk_commit", 1'b1, 0);
    chk("walk_row_out", 32'(bus.cowboy_row_out), 32'd4);
    chk("walk_col_out", 32'(bus.cowboy_col_out), 32'd4);

    // Box push up: cowboy on goal at (2,2), box at (1,2), goal beyond
    set_move(7'd2, 7'd2, 3'd4, 2'b10, 7'd1, 7'd2, 3'd5, 1'b0, 3'd1);
    for (int k = 1; k < 8; k++) begin
      push(7'd22, 3'd4, 6'(k), 2'b10);
      push(7'd12, 3'd5, 6'(k), 2'b10);
      run_frame($sformatf("push_f%0d", k), 1'b0, 0);
      chk("push_row_hold", 32'(bus.cowboy_row_out), 32'd4);
    end
    push(7'd22, 3'd1, 6'd0, 2'b00);
    push(7'd12, 3'd3, 6'd0, 2'b00);
    push(7'd2,  3'd6, 6'd0, 2'b00);
    run_frame("push_commit", 1'b1, 0);
    chk("push_row_out", 32'(bus.cowboy_row_out), 32'd1);
    chk("push_col_out", 32'(bus.cowboy_col_out), 32'd2);

    // Box push left onto plain floor: box written as plain box beyond
    set_move(7'd5, 7'd5, 3'd3, 2'b00, 7'd5, 7'd4, 3'd6, 1'b0, 3'd0);
    for (int k = 1; k < 8; k++) begin
      push(7'd55, 3'd3, 6'(k), 2'b00);
      push(7'd54, 3'd6, 6'(k), 2'b00);
      run_frame($sformatf("left_f%0d", k), 1'b0, 0);
    end
    push(7'd55, 3'd0, 6'd0, 2'b00);
    push(7'd54, 3'd4, 6'd0, 2'b00);
    push(7'd53, 3'd5, 6'd0, 2'b00);
    run_frame("left_commit", 1'b1, 0);
    chk("left_col_out", 32'(bus.cowboy_col_out), 32'd4);

    // Reset asserted during WR_N discards the frame
    set_move(7'd2, 7'd2, 3'd4, 2'b10, 7'd1, 7'd2, 3'd5, 1'b0, 3'd1);
    push(7'd22, 3'd4, 6'd1, 2'b10);
    push(7'd12, 3'd5, 6'd1, 2'b10);
    bus.process_move = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.wren) break;
    end
    check_write("rstmid_c");
    @(negedge clk);
    chk("rstmid_in_wr_n", 32'(bus.wren), 32'd1);
    check_write("rstmid_n");
    rst_n = 1'b0;
    #1;
    chk("rstmid_wren", 32'(bus.wren), 32'd0);
    chk("rstmid_row_out", 32'(bus.cowboy_row_out), 32'd0);
    bus.process_move = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(7'd22, 3'd4, 6'd1, 2'b10);
    push(7'd12, 3'd5, 6'd1, 2'b10);
    run_frame("after_rst_f1", 1'b0, 0);
    chk("after_rst_row_out", 32'(bus.cowboy_row_out), 32'd0);

    // Companion leaf modules
    fl_bits = 4'b1010; #1 chk("first_lit_1010", 32'(fl_lowest), 32'b0010);
    fl_bits = 4'b0000; #1 chk("first_lit_0000", 32'(fl_lowest), 32'b0000);
    fl_bits = 4'b1000; #1 chk("first_lit_1000", 32'(fl_lowest), 32'b1000);
    fl_bits = 4'b0111; #1 chk("first_lit_0111", 32'(fl_lowest), 32'b0001);
    hx = 4'h0; #1 chk("hex_0", 32'(seg), 32'b1000000);
    hx = 4'h1; #1 chk("hex_1", 32'(seg), 32'b1111001);
    hx = 4'h8; #1 chk("hex_8", 32'(seg), 32'b0000000);
    hx = 4'hB; #1 chk("hex_b", 32'(seg), 32'b0000011);
    hx = 4'hF; #1 chk("hex_f", 32'(seg), 32'b0001110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/entities_mover.md
ENTITIES_MOVER -- requirements
Module: entities_mover

Interface
REQ-001 SHALL have parameter ROW, default 10, cells per board row (address = row*ROW + col).
REQ-002 SHALL have parameter STEPS, default 8, frames per move; frames 1..STEPS-1 animate, frame STEPS commits.
REQ-003 SHALL have ports, one clock, async active-low reset:
  clk  in  1  system clock
  rst_n  in  1  asynchronous active-low reset
  address_write_om  out  7  object-map write address
  data_write_om  out  11  object-map write word: [10:8] type, [7:2] offset, [1:0] dir
  wren  out  1  object-map write enable
  cowboy_row_out  out  7  cowboy row after committed move
  cowboy_col_out  out  7  cowboy col after committed move
  new_state_ready  out  1  one-cycle pulse: frame written
  move_done  out  1  with new_state_ready on commit frame only
  cowboy_row / cowboy_col  in  7  cowboy cell C
  pos_cowboy  in  11  [10:8] C type (3 cowboy/empty, 4 cowboy/goal), [1:0] dir
  other_row / other_col  in  7  neighbour cell N in move direction
  pos_other  in  11  [10:8] N type (0 empty, 1 goal, 5 box, 6 box/goal)
  only_moving_cowboy  in  1  1 = no box pushed
  process_move  in  1  frame request, held high until new_state_ready seen
  field_type_after  in  3  type of cell B beyond N (0 or 1), box case only

Function
REQ-004 Dir encoding: 00 left (col-1), 01 right (col+1), 10 up (row-1), 11 down (row+1); B = N shifted by dir.
REQ-005 SHALL implement states IDLE, WR_C, WR_N, WR_B, READY, WAIT_LOW.
REQ-006 IDLE: process_move=1 sampled -> latch all inputs, frame counter k <- k+1, go WR_C next cycle.
REQ-007 Each WR_x state lasts one cycle with wren=1 and that cell's address/data; wren=0 in all other states.
REQ-008 Animation frame (k<STEPS): WR_C writes {C type, k, dir}; box case then WR_N writes {N type, k, dir}; cowboy-only skips WR_N.
REQ-009 Commit frame (k=STEPS): WR_C writes {3->0 / 4->1, 0, 00}; WR_N writes {3 if N type in {0,5}, 4 if in {1,6}, 0, 00}; box case WR_B writes {5 if field_type_after=0, 6 if 1, 0, 00}.
REQ-010 After last write -> READY: new_state_ready=1 one cycle; on commit also move_done=1, cowboy_row_out/col_out <- other_row/other_col, k <- 0.
REQ-011 READY -> WAIT_LOW; stay until process_move=0, then IDLE (a still-high process_move never starts a second frame).
REQ-012 process_move dropping in WR_x: abort to IDLE, k unchanged, no pulse.
REQ-013 Address arithmetic 7-bit unsigned; inputs guaranteed in-board; no bounds checking.
REQ-014 pos_cowboy[7:2], pos_other[7:0] ignored.
REQ-015 cowboy_row_out/col_out hold between commits.

Reset
REQ-016 rst_n=0 asynchronously: state IDLE, k=0, wren/new_state_ready/move_done=0, address/data/cowboy_*_out=0.
REQ-017 Reset mid-frame discards the move; no partial commit after release.

Structure
REQ-018 Shared package: field-type codes (0 empty,1 goal,2 wall,3,4 cowboy,5,6 box), dir codes, word field positions.
REQ-019 No sub-module; address calc and type mapping inline functions.
REQ-020 Companion leaf modules, not instantiated here: first_lit (4-bit in -> one-hot of lowest set bit, 0 if none); hextoseg (7-bit active-low segments out, 4-bit hex in, 0-F).

Verification
REQ-021 C=(4,3) type 3, dir 01, N=(4,4) type 0, only_moving=1, frame 1 -> one write addr 43 data 0x305, pulse, no move_done.
REQ-022 Same, 8th frame -> addr 43 0x000, addr 44 0x300, move_done=1, cowboy_out=(4,4).
REQ-023 C=(2,2) type 4, dir 10, N=(1,2) type 5, B type 1, 8th frame -> addr 22 0x100, addr 12 0x300, addr 2 0x600, move_done.
REQ-024 process_move held high 5 cycles after pulse -> no extra writes; next rise gives frame k+1.
REQ-025 rst_n low during WR_N -> wren=0 immediately, k=0, next request restarts at frame 1.
REQ-026 first_lit 1010 -> 0010; hextoseg 0 -> 1000000.
